// File: rtl/wb_csr_file.sv
// rtl/wb_csr_file.sv - machine-mode CSR file, 64-bit counters and trap sequencing at writeback
module wb_csr_file #(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter logic [31:0] HART_ID     = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_csr_hit,
    input  logic [11:0] wb_csr_addr,
    input  logic [1:0]  wb_csr_op,
    input  logic [31:0] wb_csr_wdata,
    input  logic [31:0] wb_pc,
    input  logic        wb_retire,
    input  logic        wb_ecall,
    input  logic        wb_ebreak,
    input  logic        wb_mret,
    output logic [31:0] csr_rdata,
    output logic        csr_illegal,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        halted
);
    typedef enum logic [1:0] {S_RUN, S_TRAP, S_RET, S_HALT} state_t;

    state_t      r_state, w_state_nxt;
    logic        r_mie, r_mpie;
    logic [31:0] r_mtvec, r_mscratch, r_mepc, r_mcause, r_redirect_pc;
    logic [63:0] r_mcycle, r_minstret;
    logic [31:0] w_old, w_new;
    logic        w_impl, w_ro, w_wr_try, w_accept, w_wr_en;
    logic        w_take_ebreak, w_take_ecall, w_take_mret;

    always_comb begin
        w_old  = 32'h0;
        w_impl = 1'b1;
        w_ro   = 1'b0;
        unique case (wb_csr_addr)
            12'h300: w_old = {24'h0, r_mpie, 3'b000, r_mie, 3'b000};
            12'h305: w_old = r_mtvec;
            12'h340: w_old = r_mscratch;
            12'h341: w_old = r_mepc;
            12'h342: w_old = r_mcause;
            12'hB00: w_old = r_mcycle[31:0];
            12'hB80: w_old = r_mcycle[63:32];
            12'hB02: w_old = r_minstret[31:0];
            12'hB82: w_old = r_minstret[63:32];
            12'hC00: begin w_old = r_mcycle[31:0];    w_ro = 1'b1; end
            12'hC80: begin w_old = r_mcycle[63:32];   w_ro = 1'b1; end
            12'hC02: begin w_old = r_minstret[31:0];  w_ro = 1'b1; end
            12'hC82: begin w_old = r_minstret[63:32]; w_ro = 1'b1; end
            12'hF14: begin w_old = HART_ID;           w_ro = 1'b1; end
            default: w_impl = 1'b0;
        endcase
    end

    always_comb begin
        w_new = w_old;
        unique case (wb_csr_op)
            2'b01:   w_new = wb_csr_wdata;
            2'b10:   w_new = w_old | wb_csr_wdata;
            2'b11:   w_new = w_old & ~wb_csr_wdata;
            default: w_new = w_old;
        endcase
    end

    // RS/RC with a zero mask is a pure read, so it may target read-only CSRs
    assign w_wr_try      = (wb_csr_op == 2'b01) || (wb_csr_op[1] && (wb_csr_wdata != 32'h0));
    assign csr_rdata     = wb_csr_hit ? w_old : 32'h0;
    assign csr_illegal   = wb_csr_hit && (!w_impl || (w_ro && w_wr_try));
    assign w_accept      = (r_state == S_RUN) || (r_state == S_RET);
    assign w_take_ebreak = w_accept && wb_ebreak;
    assign w_take_ecall  = w_accept && !wb_ebreak && wb_ecall;
    assign w_take_mret   = w_accept && !wb_ebreak && !wb_ecall && wb_mret;
    assign w_wr_en       = w_accept && wb_csr_hit && w_impl && !w_ro && w_wr_try
                           && !(wb_ecall || wb_ebreak || wb_mret);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_RUN;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_RUN, S_RET: begin
                if      (w_take_ebreak) w_state_nxt = S_HALT;
                else if (w_take_ecall)  w_state_nxt = S_TRAP;
                else if (w_take_mret)   w_state_nxt = S_RET;
                else                    w_state_nxt = S_RUN;
            end
            S_TRAP:  w_state_nxt = S_RUN;
            S_HALT:  w_state_nxt = S_HALT;
            default: w_state_nxt = S_RUN;
        endcase
    end

    always_comb begin
        redirect_valid = (r_state == S_TRAP) || (r_state == S_RET);
        halted         = (r_state == S_HALT);
    end
    assign redirect_pc = r_redirect_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mie         <= 1'b0;
            r_mpie        <= 1'b0;
            r_mtvec       <= {MTVEC_RESET[31:2], 2'b00};
            r_mscratch    <= 32'h0;
            r_mepc        <= 32'h0;
            r_mcause      <= 32'h0;
            r_redirect_pc <= 32'h0;
        end else begin
            r_redirect_pc <= 32'h0;
            if (w_take_ecall) begin
                r_mepc        <= {wb_pc[31:2], 2'b00};
                r_mcause      <= 32'd11;
                r_mpie        <= r_mie;
                r_mie         <= 1'b0;
                r_redirect_pc <= r_mtvec;
            end else if (w_take_mret) begin
                r_mie         <= r_mpie;
                r_mpie        <= 1'b1;
                r_redirect_pc <= r_mepc;
            end else if (w_wr_en) begin
                unique case (wb_csr_addr)
                    12'h300: begin r_mie <= w_new[3]; r_mpie <= w_new[7]; end
                    12'h305: r_mtvec    <= {w_new[31:2], 2'b00};
                    12'h340: r_mscratch <= w_new;
                    12'h341: r_mepc     <= {w_new[31:2], 2'b00};
                    12'h342: r_mcause   <= w_new;
                    default: ;
                endcase
            end
        end
    end

    // A write to either half replaces the increment for the whole 64-bit counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcycle   <= 64'h0;
            r_minstret <= 64'h0;
        end else begin
            if (w_wr_en && wb_csr_addr == 12'hB00)      r_mcycle[31:0]  <= w_new;
            else if (w_wr_en && wb_csr_addr == 12'hB80) r_mcycle[63:32] <= w_new;
            else if (r_state != S_HALT)                 r_mcycle        <= r_mcycle + 64'd1;

            if (w_wr_en && wb_csr_addr == 12'hB02)      r_minstret[31:0]  <= w_new;
            else if (w_wr_en && wb_csr_addr == 12'hB82) r_minstret[63:32] <= w_new;
            else if (w_accept && wb_retire)             r_minstret        <= r_minstret + 64'd1;
        end
    end
endmodule

// File: tb/tb_wb_csr_file.sv
// tb/tb_wb_csr_file.sv - randomized bench for wb_csr_file against a behavioural CSR model
module tb_wb_csr_file;
    localparam logic [31:0] P_MTVEC = 32'h0000_1003;
    localparam logic [31:0] P_HART  = 32'h0000_0005;
    localparam int MD_RUN = 0, MD_TRAP = 1, MD_RET = 2, MD_HALT = 3;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        t_hit = 1'b0, t_retire = 1'b0, t_ecall = 1'b0, t_ebreak = 1'b0, t_mret = 1'b0;
    logic [11:0] t_addr = 12'h0;
    logic [1:0]  t_op = 2'b00;
    logic [31:0] t_wdata = 32'h0, t_pc = 32'h0;
    logic [31:0] csr_rdata, redirect_pc;
    logic        csr_illegal, redirect_valid, halted;

    int n_total = 0, n_bad = 0;

    int              m_mode;
    bit              m_mie, m_mpie;
    logic [31:0]     m_mtvec, m_mscratch, m_mepc, m_mcause, m_rpc;
    longint unsigned m_cyc, m_ins;

    wb_csr_file #(.MTVEC_RESET(P_MTVEC), .HART_ID(P_HART)) dut (
        .clk(clk), .rst_n(rst_n),
        .wb_csr_hit(t_hit), .wb_csr_addr(t_addr), .wb_csr_op(t_op), .wb_csr_wdata(t_wdata),
        .wb_pc(t_pc), .wb_retire(t_retire), .wb_ecall(t_ecall), .wb_ebreak(t_ebreak),
        .wb_mret(t_mret),
        .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_mode = MD_RUN; m_mie = 0; m_mpie = 0;
        m_mtvec = P_MTVEC & ~32'd3; m_mscratch = 0; m_mepc = 0; m_mcause = 0;
        m_rpc = 0; m_cyc = 0; m_ins = 0;
    endtask

    task automatic ref_read(input logic [11:0] a, output logic [31:0] v, output bit impl, output bit ro);
        impl = 1; ro = 0; v = 0;
        case (a)
            12'h300: v = (m_mpie ? 32'h80 : 32'h0) | (m_mie ? 32'h8 : 32'h0);
            12'h305: v = m_mtvec;
            12'h340: v = m_mscratch;
            12'h341: v = m_mepc;
            12'h342: v = m_mcause;
            12'hB00: v = m_cyc[31:0];
            12'hB80: v = m_cyc[63:32];
            12'hB02: v = m_ins[31:0];
            12'hB82: v = m_ins[63:32];
            12'hC00: begin v = m_cyc[31:0];  ro = 1; end
            12'hC80: begin v = m_cyc[63:32]; ro = 1; end
            12'hC02: begin v = m_ins[31:0];  ro = 1; end
            12'hC82: begin v = m_ins[63:32]; ro = 1; end
            12'hF14: begin v = P_HART;       ro = 1; end
            default: impl = 0;
        endcase
    endtask

    function automatic bit wants_write();
        return (t_op == 2'b01) || (t_op >= 2'b10 && t_wdata != 0);
    endfunction

    task automatic model_step();
        logic [31:0] rd, nv;
        bit impl, ro;
        longint unsigned cyc_n, ins_n;
        if (m_mode == MD_HALT) return;
        ref_read(t_addr, rd, impl, ro);
        cyc_n = m_cyc + 1;
        ins_n = (m_mode != MD_TRAP && t_retire) ? m_ins + 1 : m_ins;
        m_rpc = 0;
        if (m_mode == MD_TRAP) begin
            m_mode = MD_RUN;
        end else if (t_ebreak) begin
            m_mode = MD_HALT;
        end else if (t_ecall) begin
            m_mepc = t_pc & ~32'd3; m_mcause = 11; m_mpie = m_mie; m_mie = 0;
            m_rpc = m_mtvec; m_mode = MD_TRAP;
        end else if (t_mret) begin
            m_mie = m_mpie; m_mpie = 1; m_rpc = m_mepc; m_mode = MD_RET;
        end else begin
            m_mode = MD_RUN;
            if (t_hit && impl && !ro && wants_write()) begin
                if (t_op == 2'b01)      nv = t_wdata;
                else if (t_op == 2'b10) nv = rd | t_wdata;
                else                    nv = rd & ~t_wdata;
                case (t_addr)
                    12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
                    12'h305: m_mtvec = nv & ~32'd3;
                    12'h340: m_mscratch = nv;
                    12'h341: m_mepc = nv & ~32'd3;
                    12'h342: m_mcause = nv;
                    12'hB00: cyc_n = (m_cyc & 64'hFFFF_FFFF_0000_0000) | nv;
                    12'hB80: cyc_n = (m_cyc & 64'h0000_0000_FFFF_FFFF) | (longint'(nv) << 32);
                    12'hB02: ins_n = (m_ins & 64'hFFFF_FFFF_0000_0000) | nv;
                    12'hB82: ins_n = (m_ins & 64'h0000_0000_FFFF_FFFF) | (longint'(nv) << 32);
                    default: ;
                endcase
            end
        end
        m_cyc = cyc_n; m_ins = ins_n;
    endtask

    task automatic check_outputs();
        logic [31:0] rd;
        bit impl, ro;
        ref_read(t_addr, rd, impl, ro);
        chk("rdata", csr_rdata, t_hit ? rd : 32'h0);
        chk("illegal", csr_illegal, t_hit && (!impl || (ro && wants_write())));
        chk("redirect_valid", redirect_valid, m_mode == MD_TRAP || m_mode == MD_RET);
        chk("redirect_pc", redirect_pc, m_rpc);
        chk("halted", halted, m_mode == MD_HALT);
    endtask

    // Inputs change at posedge+1; outputs are compared at the negedge
    task automatic step();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic drive(input bit hit, input logic [11:0] a, input logic [1:0] op, input logic [31:0] wd);
        t_hit = hit; t_addr = a; t_op = op; t_wdata = wd;
        t_ecall = 0; t_ebreak = 0; t_mret = 0; t_retire = 0;
    endtask

    task automatic do_reset();
        rst_n = 0; m_reset();
        #1;
        chk("reset_rvalid", redirect_valid, 1'b0);
        chk("reset_halted", halted, 1'b0);
        rst_n = 1;
    endtask

    initial begin
        m_reset();
        #12;
        chk("reset_rdata", csr_rdata, 32'h0);
        chk("reset_illegal", csr_illegal, 1'b0);
        chk("reset_rvalid", redirect_valid, 1'b0);
        chk("reset_rpc", redirect_pc, 32'h0);
        chk("reset_halted", halted, 1'b0);
        drive(1, 12'h305, 2'b00, 0); #1;
        chk("reset_mtvec", csr_rdata, 32'h0000_1000);
        #3 rst_n = 1; #1;

        drive(1, 12'h305, 2'b01, 32'h8000_0103); #1;
        chk("mtvec_old", csr_rdata, 32'h0000_1000);
        step();
        drive(1, 12'h305, 2'b00, 0); #1;
        chk("mtvec_new", csr_rdata, 32'h8000_0100);
        step();

        drive(1, 12'hB00, 2'b01, 32'hFFFF_FFFE); step();
        drive(1, 12'hB80, 2'b01, 32'h0);         step();
        drive(0, 12'h0, 2'b00, 0); step(); step();
        drive(1, 12'hB80, 2'b00, 0); #1;
        chk("mcycleh_carry", csr_rdata, 32'h1);
        t_addr = 12'hB00; #1;
        chk("mcycle_wrap", csr_rdata, 32'h0);
        step();

        drive(1, 12'hB00, 2'b01, 32'hFFFF_FFFF); step();
        drive(1, 12'hB80, 2'b01, 32'hFFFF_FFFF); step();
        drive(1, 12'hB80, 2'b00, 0); step();
        chk("mcycle64_wrap_hi", csr_rdata, 32'h0);
        t_addr = 12'hB00; #1;
        chk("mcycle64_wrap_lo", csr_rdata, 32'h0);
        step();

        drive(1, 12'h305, 2'b01, 32'h0000_0200); step();
        drive(1, 12'h300, 2'b10, 32'h0000_0008); step();
        drive(0, 12'h0, 2'b00, 0); t_ecall = 1; t_pc = 32'h0000_0124; step();
        drive(0, 12'h0, 2'b00, 0);
        chk("ecall_rvalid", redirect_valid, 1'b1);
        chk("ecall_rpc", redirect_pc, 32'h0000_0200);
        step();
        chk("ecall_pulse_end", redirect_valid, 1'b0);
        drive(1, 12'h341, 2'b00, 0); #1; chk("mepc", csr_rdata, 32'h124);
        t_addr = 12'h342; #1; chk("mcause", csr_rdata, 32'd11);
        t_addr = 12'h300; #1; chk("mstatus_trap", csr_rdata, 32'h80);
        step();

        drive(0, 12'h0, 2'b00, 0); t_mret = 1; step();
        drive(1, 12'h300, 2'b00, 0);
        chk("mret_rvalid", redirect_valid, 1'b1);
        chk("mret_rpc", redirect_pc, 32'h124);
        step();
        chk("mstatus_ret", csr_rdata, 32'h88);

        drive(0, 12'h0, 2'b00, 0); t_ecall = 1; step();
        drive(0, 12'h0, 2'b00, 0);
        chk("trap_before_rst", redirect_valid, 1'b1);
        do_reset();
        step();

        drive(1, 12'hC00, 2'b01, 32'h1234); #1;
        chk("ro_write_illegal", csr_illegal, 1'b1);
        step(); step();
        drive(1, 12'h7C0, 2'b00, 0); #1;
        chk("unimpl_rdata", csr_rdata, 32'h0);
        chk("unimpl_illegal", csr_illegal, 1'b1);
        step();

        begin
            logic [11:0] addrs [16] = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'hB00,
                                        12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC80, 12'hC02,
                                        12'hC82, 12'hF14, 12'h7C0, 12'h123};
            for (int i = 0; i < 3000; i++) begin
                t_hit    = ($urandom % 4) != 0;
                t_addr   = addrs[$urandom % 16];
                t_op     = 2'($urandom);
                case ($urandom % 4)
                    0:       t_wdata = 0;
                    1:       t_wdata = 32'hFFFF_FFFF - ($urandom % 4);
                    default: t_wdata = $urandom;
                endcase
                t_pc     = $urandom;
                t_retire = $urandom % 2;
                t_ecall  = ($urandom % 20) == 0;
                t_mret   = ($urandom % 20) == 0;
                t_ebreak = 0;
                if (($urandom % 250) == 0) do_reset();
                step();
            end
        end

        begin
            logic [31:0] frozen, scratch;
            drive(0, 12'h0, 2'b00, 0); t_ebreak = 1; t_ecall = 1; step();
            drive(1, 12'h340, 2'b01, 32'hDEAD_BEEF);
            chk("halt_set", halted, 1'b1);
            chk("halt_no_redirect", redirect_valid, 1'b0);
            scratch = m_mscratch;
            frozen  = m_cyc[31:0];
            step();
            drive(1, 12'hB00, 2'b00, 0);
            for (int i = 0; i < 10; i++) step();
            chk("cycle_frozen", csr_rdata, frozen);
            t_addr = 12'h340; #1;
            chk("halt_write_ignored", csr_rdata, scratch);
            step();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/wb_csr_file.md
Name: wb_csr_file

Overview:
- Machine-mode CSR responder at the far end of the MEM/WB register.
- Consumes the WB-stage CSR request (hit, address, op, write data) plus the retire, ecall, ebreak and mret flags.
- Returns combinational read data for writeback, owns the 64-bit cycle/instret counters, and sequences traps into a one-cycle PC redirect or a sticky halt.

Parameters:
- MTVEC_RESET, 32'h0000_0000, reset value of mtvec (bits [1:0] forced 0).
- HART_ID, 0, value returned for mhartid (0xF14).

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- wb_csr_hit  in  1  WB instruction is a CSR access
- wb_csr_addr  in  12  CSR address
- wb_csr_op  in  2  00 none, 01 RW, 10 RS, 11 RC
- wb_csr_wdata  in  32  rs1 value or zero-extended uimm
- wb_pc  in  32  PC of WB instruction
- wb_retire  in  1  valid instruction retires this cycle
- wb_ecall  in  1  ECALL in WB
- wb_ebreak  in  1  EBREAK in WB
- wb_mret  in  1  MRET in WB
- csr_rdata  out  32  old CSR value (combinational)
- csr_illegal  out  1  hit to an unimplemented address, or a write to a read-only CSR
- redirect_valid  out  1  one-cycle PC redirect pulse
- redirect_pc  out  32  redirect target
- halted  out  1  sticky after EBREAK

Behaviour:
- Implemented CSRs:
  - mstatus 0x300: only MIE[3] and MPIE[7] are writable.
  - mtvec 0x305; mscratch 0x340; mepc 0x341; mcause 0x342.
  - mcycle 0xB00, mcycleh 0xB80, minstret 0xB02, minstreth 0xB82.
  - Read-only: cycle 0xC00, cycleh 0xC80, instret 0xC02, instreth 0xC82, mhartid 0xF14.
- Reset (async, rst_n low), all outputs 0:
  - mstatus 0, mtvec MTVEC_RESET, mscratch/mepc/mcause 0, counters 0.
  - FSM state RUN; halted 0, redirect_valid 0, redirect_pc 0.
  - Reset mid-trap aborts the pending redirect.
- Read path:
  - csr_rdata is combinational from wb_csr_addr when wb_csr_hit=1, otherwise 0.
  - Always returns the pre-write value.
  - Unimplemented address: rdata 0, csr_illegal=1, no state change.
- Write path, at the clock edge when wb_csr_hit and op!=00 and not halted:
  - RW: new = wdata. RS: new = old | wdata. RC: new = old & ~wdata.
  - RS/RC with wdata=0 performs no write.
  - Writing a read-only address raises csr_illegal=1 and the write is dropped.
  - mtvec[1:0] and mepc[1:0] are always stored as 0.
- Counters:
  - mcycle increments by 1 every cycle while not halted.
  - minstret increments when wb_retire=1 and not halted.
  - Full 64-bit carry: low-half wrap 0xFFFF_FFFF -> 0 increments the high half.
  - A CSR write to either half in the same cycle wins over the increment for the entire 64-bit counter that cycle (no increment, other half held).
  - 64-bit all-ones wraps to 0.
- FSM:
  - RUN: highest-priority event wins, priority ebreak > ecall > mret.
    - wb_ebreak -> HALT: halted=1 next cycle; counters freeze.
    - wb_ecall -> TRAP: mepc<=wb_pc, mcause<=32'd11, MPIE<=MIE, MIE<=0.
    - wb_mret -> RET: MIE<=MPIE, MPIE<=1.
    - Any CSR write in the same cycle as ecall/ebreak/mret is suppressed.
  - TRAP: redirect_valid=1, redirect_pc=mtvec (value after any prior write) for exactly one cycle, then RUN. WB inputs are ignored while in TRAP (pipeline is being flushed).
  - RET: redirect_valid=1, redirect_pc=mepc for one cycle, then RUN.
  - HALT: absorbing until rst_n; all writes and events are ignored.
- redirect_valid and redirect_pc are registered: the pulse appears the cycle after the event is sampled.

Test Plan:
- Reset, then csr_hit addr 0x305 op RW wdata 0x8000_0103:
  - next cycle read of 0x305 returns 0x8000_0100;
  - csr_rdata during the write cycle returns MTVEC_RESET.
- Write mcycle=0xFFFF_FFFE, mcycleh=0 (one write per cycle), then stop writing:
  - 2 cycles later mcycleh reads 1 and mcycle reads 0.
- wb_ecall with wb_pc=0x0000_0124, mtvec=0x0000_0200, MIE=1:
  - next cycle redirect_valid=1 for 1 cycle, redirect_pc=0x200;
  - mepc reads 0x124, mcause reads 11, mstatus reads 0x80.
- wb_mret after the above: redirect_pc=0x124 one cycle later; mstatus reads 0x88.
- wb_ebreak and wb_ecall together:
  - halted=1, no redirect pulse;
  - mcycle frozen across 10 cycles;
  - RW to 0x340 is ignored.
- csr_hit 0xC00 op RW → csr_illegal=1, cycle counter unchanged. Hit 0x7C0 → rdata 0, csr_illegal=1. Assert rst_n low during the TRAP cycle → redirect_valid drops immediately, FSM returns to RUN.
